// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide on magnitudes, sign fixed at the end.
// Latency DATA_WIDTH+1 cycles after accept (1 for divide-by-zero/overflow); stalls upstream while busy.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  input  logic [2:0]            op_in,
  input  logic [DATA_WIDTH-1:0] opr_a,
  input  logic [DATA_WIDTH-1:0] opr_b,
  input  logic                  flush_in,
  output logic                  ready_out,
  output logic                  stall_out,
  output logic                  result_valid_out,
  output logic [DATA_WIDTH-1:0] result_out
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      op_q;
  logic            a_neg_q, b_neg_q;
  logic [W-1:0]    opd_q, hi_q, lo_q;

  logic            accept, a_signed, b_signed, a_neg, b_neg;
  logic [W-1:0]    a_mag, b_mag;
  logic            div_zero, div_ovf, shortcut;
  logic [W-1:0]    short_res;
  logic [W:0]      mul_sum, div_r;
  logic            div_ge, last_iter;
  logic [W-1:0]    hi_n, lo_n, quo, rem, final_res;
  logic [2*W-1:0]  prod, prod_s;

  // operand decode and magnitudes, evaluated at acceptance
  always_comb begin
    accept    = (state_q == IDLE) && valid_in && !flush_in;
    a_signed  = (op_in == 3'd1) || (op_in == 3'd2) || (op_in == 3'd4) || (op_in == 3'd6);
    b_signed  = (op_in == 3'd1) || (op_in == 3'd4) || (op_in == 3'd6);
    a_neg     = a_signed && opr_a[W-1];
    b_neg     = b_signed && opr_b[W-1];
    a_mag     = a_neg ? (~opr_a + 1'b1) : opr_a;
    b_mag     = b_neg ? (~opr_b + 1'b1) : opr_b;
    div_zero  = op_in[2] && (opr_b == '0);
    div_ovf   = op_in[2] && !op_in[0] && (opr_a == {1'b1, {(W-1){1'b0}}}) && (opr_b == '1);
    shortcut  = div_zero || div_ovf;
    if (div_zero) short_res = op_in[1] ? opr_a : '1;
    else          short_res = op_in[1] ? '0 : opr_a;
  end

  // one iteration per CALC cycle; hi/lo hold product halves or remainder/quotient
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
    div_r     = {hi_q, lo_q[W-1]};
    div_ge    = div_r >= {1'b0, opd_q};
    if (op_q[2]) begin
      hi_n = div_ge ? (div_r[W-1:0] - opd_q) : div_r[W-1:0];
      lo_n = {lo_q[W-2:0], div_ge};
    end else begin
      hi_n = mul_sum[W:1];
      lo_n = {mul_sum[0], lo_q[W-1:1]};
    end
    prod      = {hi_n, lo_n};
    prod_s    = (a_neg_q ^ b_neg_q) ? (~prod + 1'b1) : prod;
    quo       = (a_neg_q ^ b_neg_q) ? (~lo_n + 1'b1) : lo_n;
    rem       = a_neg_q ? (~hi_n + 1'b1) : hi_n;
    case (op_q)
      3'd0:                final_res = prod_s[W-1:0];
      3'd1, 3'd2, 3'd3:    final_res = prod_s[2*W-1:W];
      3'd4, 3'd5:          final_res = quo;
      default:             final_res = rem;
    endcase
    last_iter = (cnt_q == CW'(W - 1));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = shortcut ? DONE : CALC;
      CALC:    if (flush_in) state_d = IDLE;
               else if (last_iter) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_out        = (state_q == IDLE);
    stall_out        = accept || (state_q == CALC);
    result_valid_out = (state_q == DONE) && !flush_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      op_q       <= '0;
      a_neg_q    <= 1'b0;
      b_neg_q    <= 1'b0;
      opd_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      result_out <= '0;
    end else if (accept) begin
      cnt_q   <= '0;
      op_q    <= op_in;
      a_neg_q <= a_neg;
      b_neg_q <= b_neg;
      opd_q   <= op_in[2] ? b_mag : a_mag;
      hi_q    <= '0;
      lo_q    <= op_in[2] ? a_mag : b_mag;
      if (shortcut) result_out <= short_res;
    end else if ((state_q == CALC) && !flush_in) begin
      cnt_q <= cnt_q + 1'b1;
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      if (last_iter) result_out <= final_res;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: RV32M result values, cycle timing, shortcuts, flush and async reset.
module tb_muldiv_unit;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_in;
  logic [2:0]    op_in;
  logic [W-1:0]  opr_a, opr_b;
  logic          flush_in;
  logic          ready_out, stall_out, result_valid_out;
  logic [W-1:0]  result_out;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .op_in(op_in),
    .opr_a(opr_a), .opr_b(opr_b), .flush_in(flush_in),
    .ready_out(ready_out), .stall_out(stall_out),
    .result_valid_out(result_valid_out), .result_out(result_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present op in the cycle ending at the accept edge, scramble inputs afterwards,
  // then walk the CALC cycles and check the DONE pulse and the return to IDLE.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp, input bit short_cut);
    logic bad;
    @(negedge clk);
    valid_in = 1'b1; op_in = op; opr_a = a; opr_b = b;
    #1;
    chk({tag, "_stall_pre"}, W'(stall_out), W'(1));
    @(posedge clk); #1;
    valid_in = 1'b0; op_in = ~op; opr_a = ~a; opr_b = a ^ b ^ 32'h1;
    if (!short_cut) begin
      bad = 1'b0;
      for (int i = 0; i < W; i++) begin
        if (stall_out !== 1'b1 || result_valid_out !== 1'b0 || ready_out !== 1'b0) bad = 1'b1;
        @(posedge clk); #1;
      end
      chk({tag, "_calc_hold"}, W'(bad), W'(0));
    end
    chk({tag, "_valid"}, W'(result_valid_out), W'(1));
    chk({tag, "_stall_done"}, W'(stall_out), W'(0));
    chk({tag, "_result"}, result_out, exp);
    @(posedge clk); #1;
    chk({tag, "_idle_valid"}, W'(result_valid_out), W'(0));
    chk({tag, "_idle_ready"}, W'(ready_out), W'(1));
    chk({tag, "_hold"}, result_out, exp);
  endtask

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; op_in = '0; opr_a = '0; opr_b = '0; flush_in = 1'b0;
    #1;
    chk("rst_ready", W'(ready_out), W'(1));
    chk("rst_stall", W'(stall_out), W'(0));
    chk("rst_valid", W'(result_valid_out), W'(0));
    chk("rst_result", result_out, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    run_op("mul_7x6",   3'd0, 32'd7,        32'd6,        32'd42,       1'b0);
    run_op("mul_neg",   3'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 1'b0);
    run_op("mulh",      3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0);
    run_op("mulhu",     3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    run_op("mulhsu",    3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0);
    run_op("div_m7_2",  3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0);
    run_op("rem_m7_2",  3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0);
    run_op("divu",      3'd5, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 1'b0);
    run_op("remu_100_7",3'd7, 32'd100,      32'd7,        32'd2,        1'b0);
    run_op("divu_z",    3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1);
    run_op("remu_z",    3'd7, 32'd5,        32'd0,        32'd5,        1'b1);

    // flush a DIV in cycle T+10, then accept a MUL at edge T+11
    @(negedge clk);
    valid_in = 1'b1; op_in = 3'd4; opr_a = 32'd100; opr_b = 32'd7;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush_in = 1'b1;
    #1;
    chk("flush_valid", W'(result_valid_out), W'(0));
    @(posedge clk); #1;
    flush_in = 1'b0;
    chk("flush_ready", W'(ready_out), W'(1));
    chk("flush_result", result_out, 32'd5);
    run_op("mul_after_flush", 3'd0, 32'd3, 32'd5, 32'd15, 1'b0);

    run_op("div_ovf",   3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
    run_op("rem_ovf",   3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1'b1);

    // async reset mid-CALC, between clock edges
    @(negedge clk);
    valid_in = 1'b1; op_in = 3'd0; opr_a = 32'd9; opr_b = 32'd9;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    #2; rst_n = 1'b0; #1;
    chk("arst_ready", W'(ready_out), W'(1));
    chk("arst_stall", W'(stall_out), W'(0));
    chk("arst_valid", W'(result_valid_out), W'(0));
    chk("arst_result", result_out, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("arst_hold_valid", W'(result_valid_out), W'(0));
    @(negedge clk); rst_n = 1'b1;
    run_op("mul_after_rst", 3'd0, 32'd2, 32'd3, 32'd6, 1'b0);

    // valid with flush in IDLE is never accepted
    @(negedge clk);
    valid_in = 1'b1; flush_in = 1'b1; op_in = 3'd0; opr_a = 32'd4; opr_b = 32'd4;
    #1;
    chk("vf_stall", W'(stall_out), W'(0));
    repeat (3) begin @(posedge clk); #1; end
    chk("vf_ready", W'(ready_out), W'(1));
    chk("vf_stall_late", W'(stall_out), W'(0));
    chk("vf_valid", W'(result_valid_out), W'(0));
    chk("vf_result", result_out, 32'd6);
    valid_in = 1'b0; flush_in = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32: operand and result width.
REQ-002 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port valid_in  input  1  execute stage presents an M-extension op.
REQ-005 Port op_in  input  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 Port opr_a  input  DATA_WIDTH  rs1 operand (dividend / multiplicand).
REQ-007 Port opr_b  input  DATA_WIDTH  rs2 operand (divisor / multiplier).
REQ-008 Port flush_in  input  1  pipeline flush; abort the current op.
REQ-009 Port ready_out  output  1  unit idle, can accept an op.
REQ-010 Port stall_out  output  1  hold the upstream pipeline stages.
REQ-011 Port result_valid_out  output  1  one-cycle pulse, result_out is valid.
REQ-012 Port result_out  output  DATA_WIDTH  operation result.

Function
REQ-013 FSM states: IDLE, CALC, DONE. Encoding is implementation choice.
REQ-014 ready_out SHALL be 1 in IDLE only.
REQ-015 An op is accepted on a rising edge in IDLE with valid_in=1 and flush_in=0.
- op_in, opr_a and opr_b are captured at acceptance.
- Later input changes SHALL NOT affect the op.
REQ-016 valid_in SHALL be ignored in CALC and DONE.
REQ-017 Transition IDLE->CALC on acceptance, except the shortcut cases in REQ-022/023, which go IDLE->DONE.
REQ-018 CALC lasts exactly DATA_WIDTH cycles, one iteration per cycle, counted by an internal counter of clog2(DATA_WIDTH)+1 bits. Then CALC->DONE.
REQ-019 DONE lasts one cycle, then DONE->IDLE.
- result_valid_out=1 in DONE only.
- result_out updates on entry to DONE and holds until the next DONE.
REQ-020 Latency: accepted at edge T gives result_valid_out high in cycle T+DATA_WIDTH+1 (normal) or T+1 (shortcut). Back-to-back accept is possible at the cycle after DONE.
REQ-021 Arithmetic is iterative: shift-add multiply and restoring divide on operand magnitudes, with the sign applied in the final step.
- MUL: low DATA_WIDTH bits of the product.
- MULH: high half, signed x signed.
- MULHSU: high half, signed a x unsigned b.
- MULHU: high half, unsigned x unsigned.
- DIV/DIVU: quotient truncated toward zero.
- REM/REMU: remainder, with the sign of the dividend.
REQ-022 Divide by zero (opr_b=0, ops 4-7) is a shortcut:
- DIV/DIVU give all-ones.
- REM/REMU give opr_a.
REQ-023 Signed overflow (DIV/REM, opr_a=most-negative, opr_b=all-ones) is a shortcut:
- DIV gives opr_a.
- REM gives 0.
REQ-024 stall_out = (IDLE and valid_in and not flush_in) or CALC. It is 0 in DONE, so the pipeline advances with the result.
REQ-025 flush_in=1 in CALC or DONE SHALL return the FSM to IDLE on the next edge.
- result_valid_out is 0 in that cycle.
- result_out is unchanged.
REQ-026 flush_in and valid_in together in IDLE: flush wins, the op is not accepted, and stall_out=0.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, counter 0, result_out 0, result_valid_out 0, stall_out 0 and all internal operand/accumulator registers to 0. ready_out=1 while in reset.
REQ-028 Reset asserted mid-CALC aborts the op with no result pulse. The first accept is possible on the first rising edge after rst_n deasserts.

Verification
REQ-029 MUL: opr_a=7, opr_b=6, accept at T -> result_valid_out pulse in cycle T+33, result_out=42, stall_out high T..T+32, low at T+33.
REQ-030 MULH: 0x80000000 x 0x80000000 -> 0x40000000. MULHU: 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU: 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-031 Signed divide: DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC.
REQ-032 Shortcut cases, result valid at T+1:
- DIVU 5/0 -> 0xFFFFFFFF.
- REMU 5/0 -> 5.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
- REM 0x80000000/0xFFFFFFFF -> 0.
REQ-033 Abort and resume:
- flush_in at T+10 of a DIV -> no result_valid_out, ready_out=1 at T+11, result_out unchanged.
- A new MUL accepted at T+11 completes normally at T+44.
REQ-034 Async reset:
- rst_n low mid-CALC (T+5) -> outputs reset without waiting for a clock edge, no result pulse.
- valid_in held high with flush_in=1 in IDLE -> never accepted, stall_out=0.
